// File: rtl/aes_mode_stream.sv
// ============================================================================
// Module   : aes_mode_stream
// Purpose  : Streams 128-bit blocks through an external AES core in ECB, CBC
//            or CTR mode, keeping the chaining value/counter across blocks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_mode_stream #(
    parameter int CORE_LAT = 0,
    parameter int CTR_W    = 32,
    parameter int KEY_W    = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [127:0]     iv,
    input  logic             iv_load,
    input  logic [KEY_W-1:0] key,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [127:0]     core_in,
    output logic [KEY_W-1:0] core_key,
    input  logic [127:0]     core_out
);

    localparam int               CNT_W    = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(CORE_LAT);
    // Counter field occupies the low CTR_W bits; the rest of the block is fixed.
    localparam logic [127:0]     CTR_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                            : ((128'd1 << CTR_W) - 128'd1);
    localparam logic [1:0]       C_MODE_CBC = 2'b01;
    localparam logic [1:0]       C_MODE_CTR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [127:0]     chain_q,     chain_d;
    logic [127:0]     out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       mode_q,      mode_d;
    logic [KEY_W-1:0] key_q,       key_d;
    logic [127:0]     pt_q,        pt_d;
    logic [127:0]     core_in_q,   core_in_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            chain_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            mode_q      <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            core_in_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            chain_q     <= chain_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            core_in_q   <= core_in_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        chain_d     = chain_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mode_d      = mode_q;
        key_d       = key_q;
        pt_d        = pt_q;
        core_in_d   = core_in_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                // A pending IV load takes priority over accepting a block.
                if (iv_load) begin
                    chain_d = iv;
                end else if (in_valid) begin
                    mode_d  = mode;
                    key_d   = key;
                    pt_d    = in_data;
                    cnt_d   = LAT_INIT;
                    state_d = RUN;
                    case (mode)
                        C_MODE_CBC: core_in_d = in_data ^ chain_q;
                        C_MODE_CTR: core_in_d = chain_q;
                        default:    core_in_d = in_data;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    case (mode_q)
                        C_MODE_CBC: begin
                            out_data_d = core_out;
                            chain_d    = core_out;
                        end
                        C_MODE_CTR: begin
                            out_data_d = core_out ^ pt_q;
                            chain_d    = (chain_q & ~CTR_MASK) | ((chain_q + 128'd1) & CTR_MASK);
                        end
                        default: out_data_d = core_out;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !iv_load;
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign core_in   = core_in_q;
    assign core_key  = key_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_mode_stream.sv
// ============================================================================
// Module   : tb_aes_mode_stream
// Purpose  : Directed vectors for aes_mode_stream with a stand-in core model,
//            one instance combinational (CORE_LAT=0), one pipelined (CORE_LAT=3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_mode_stream;

    localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] IVC = 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_ffffffff;
    localparam logic [127:0] IVW = 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_00000000;
    localparam logic [127:0] IVX = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] D1  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] D2  = 128'h13579bdf_2468ace0_fedcba98_76543210;

    // Stand-in cipher: returns the FIPS-197 answer for its test vector and a
    // cheap keyed permutation otherwise; the mode logic is agnostic to it.
    function automatic logic [127:0] f(input logic [127:0] x, input logic [127:0] k);
        if (x == PT && k == K) return CT;
        return {x[100:0], x[127:101]} ^ k ^ 128'h3c3c3c3c_c3c3c3c3_5a5a5a5a_a5a5a5a5;
    endfunction

    logic         clk = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [127:0] iv = '0;
    logic [127:0] key = K;
    logic [127:0] in_data = '0;
    logic         rst_s[2];
    logic         iv_load_s[2];
    logic         in_valid_s[2];
    logic         out_ready_s[2];
    logic         in_ready_s[2];
    logic         out_valid_s[2];
    logic         busy_s[2];
    logic [127:0] out_data_s[2];
    logic [127:0] core_in_s[2];
    logic [127:0] core_key_s[2];
    logic [127:0] core_out_s[2];
    logic [127:0] chain_s[2];
    logic [127:0] pipe1, pipe2, pipe3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_mode_stream #(.CORE_LAT(0), .CTR_W(32), .KEY_W(128)) dut_l0 (
        .clk(clk), .rst(rst_s[0]), .mode(mode), .iv(iv), .iv_load(iv_load_s[0]),
        .key(key), .in_data(in_data), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .out_data(out_data_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .busy(busy_s[0]), .core_in(core_in_s[0]), .core_key(core_key_s[0]),
        .core_out(core_out_s[0])
    );

    aes_mode_stream #(.CORE_LAT(3), .CTR_W(32), .KEY_W(128)) dut_l3 (
        .clk(clk), .rst(rst_s[1]), .mode(mode), .iv(iv), .iv_load(iv_load_s[1]),
        .key(key), .in_data(in_data), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .out_data(out_data_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .busy(busy_s[1]), .core_in(core_in_s[1]), .core_key(core_key_s[1]),
        .core_out(core_out_s[1])
    );

    assign core_out_s[0] = f(core_in_s[0], core_key_s[0]);
    always @(posedge clk) begin
        pipe1 <= f(core_in_s[1], core_key_s[1]);
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end
    assign core_out_s[1] = pipe3;
    assign chain_s[0]    = dut_l0.chain_q;
    assign chain_s[1]    = dut_l3.chain_q;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ivload(input int u, input logic [127:0] v);
        @(negedge clk);
        iv = v;
        iv_load_s[u] = 1'b1;
        @(posedge clk);
        #1 iv_load_s[u] = 1'b0;
    endtask

    task automatic accept(input int u, input logic [1:0] m, input logic [127:0] d,
                          output logic [127:0] cin);
        @(negedge clk);
        mode = m;
        in_data = d;
        in_valid_s[u] = 1'b1;
        @(posedge clk);
        #1 in_valid_s[u] = 1'b0;
        cin = core_in_s[u];
        chk("accept_busy", {127'd0, busy_s[u]}, 128'd1);
    endtask

    task automatic wait_valid(input int u, output int cyc);
        cyc = 0;
        while (out_valid_s[u] !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic drain(input int u);
        @(negedge clk);
        out_ready_s[u] = 1'b1;
        @(posedge clk);
        #1 out_ready_s[u] = 1'b0;
        chk("drain_valid", {127'd0, out_valid_s[u]}, 128'd0);
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic         ld;
        logic [127:0] ivv;
        logic [127:0] data;
        logic [127:0] exp_cin;
        logic [127:0] exp_out;
        logic [127:0] exp_chain;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] cin, od, exp, chain_before, cin6;
        logic         bp_ok, ov_seen;
        int           cyc;

        cin6 = D2 ^ (IVW | 128'd1);
        vecs[0] = '{2'b00, 1'b1, 128'd0, PT, PT, CT, 128'd0};
        vecs[1] = '{2'b01, 1'b1, 128'd0, PT, PT, CT, CT};
        vecs[2] = '{2'b01, 1'b0, 128'd0, CT, 128'd0, f(128'd0, K), f(128'd0, K)};
        vecs[3] = '{2'b10, 1'b1, IVC, D1, IVC, f(IVC, K) ^ D1, IVW};
        vecs[4] = '{2'b10, 1'b0, 128'd0, D2, IVW, f(IVW, K) ^ D2, IVW | 128'd1};
        vecs[5] = '{2'b11, 1'b0, 128'd0, D1, D1, f(D1, K), IVW | 128'd1};
        vecs[6] = '{2'b01, 1'b0, 128'd0, D2, cin6, f(cin6, K), f(cin6, K)};

        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; iv_load_s[u] = 1'b0; in_valid_s[u] = 1'b0; out_ready_s[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst%0d_out_valid", u), {127'd0, out_valid_s[u]}, 128'd0);
            chk($sformatf("rst%0d_busy", u), {127'd0, busy_s[u]}, 128'd0);
            chk($sformatf("rst%0d_in_ready", u), {127'd0, in_ready_s[u]}, 128'd1);
            chk($sformatf("rst%0d_out_data", u), out_data_s[u], 128'd0);
            chk($sformatf("rst%0d_core_in", u), core_in_s[u], 128'd0);
            chk($sformatf("rst%0d_core_key", u), core_key_s[u], 128'd0);
            chk($sformatf("rst%0d_chain", u), chain_s[u], 128'd0);
        end

        // Table vectors on the combinational-core instance.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].ld) ivload(0, vecs[i].ivv);
            accept(0, vecs[i].mode, vecs[i].data, cin);
            chk($sformatf("v%0d_core_in", i), cin, vecs[i].exp_cin);
            wait_valid(0, cyc);
            chk($sformatf("v%0d_latency", i), 128'(cyc), 128'd1);
            chk($sformatf("v%0d_out", i), out_data_s[0], vecs[i].exp_out);
            chk($sformatf("v%0d_chain", i), chain_s[0], vecs[i].exp_chain);
            drain(0);
        end

        // FIPS-197 ECB through the 3-cycle core.
        accept(1, 2'b00, PT, cin);
        chk("l3_ecb_core_in", cin, PT);
        wait_valid(1, cyc);
        chk("l3_ecb_latency", 128'(cyc), 128'd4);
        chk("l3_ecb_out", out_data_s[1], CT);
        drain(1);

        // Backpressure with disturbing inputs while holding.
        ivload(1, 128'h1234);
        exp = f(PT ^ 128'h1234, K);
        accept(1, 2'b01, PT, cin);
        wait_valid(1, cyc);
        chk("bp_latency", 128'(cyc), 128'd4);
        chk("bp_out", out_data_s[1], exp);
        chain_before = chain_s[1];
        chk("bp_chain", chain_before, exp);
        bp_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv_load_s[1] = ~iv_load_s[1];
            in_valid_s[1] = 1'b1;
            mode = 2'(i);
            key = K ^ {96'd0, 32'($urandom)};
            iv = {96'd0, 32'($urandom)};
            @(posedge clk);
            #1;
            if (out_data_s[1] !== exp || in_ready_s[1] !== 1'b0 || out_valid_s[1] !== 1'b1 ||
                chain_s[1] !== chain_before || core_key_s[1] !== K)
                bp_ok = 1'b0;
        end
        chk("bp_stable", {127'd0, bp_ok}, 128'd1);
        @(negedge clk);
        iv_load_s[1] = 1'b0;
        in_valid_s[1] = 1'b0;
        key = K;
        drain(1);
        chk("bp_chain_after", chain_s[1], chain_before);

        // iv_load and in_valid together: load wins, block goes next cycle.
        @(negedge clk);
        iv = IVX;
        iv_load_s[1] = 1'b1;
        in_valid_s[1] = 1'b1;
        mode = 2'b01;
        in_data = PT;
        #1 chk("sim_in_ready", {127'd0, in_ready_s[1]}, 128'd0);
        @(posedge clk);
        #1 iv_load_s[1] = 1'b0;
        chk("sim_not_accepted", {127'd0, busy_s[1]}, 128'd0);
        chk("sim_chain", chain_s[1], IVX);
        @(posedge clk);
        #1 in_valid_s[1] = 1'b0;
        chk("sim_accepted", {127'd0, busy_s[1]}, 128'd1);
        chk("sim_core_in", core_in_s[1], PT ^ IVX);
        wait_valid(1, cyc);
        exp = f(PT ^ IVX, K);
        chk("sim_out", out_data_s[1], exp);
        drain(1);

        // out_ready while idle is harmless; out_data keeps its last value.
        @(negedge clk);
        out_ready_s[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready_s[1] = 1'b0;
        chk("idle_out_valid", {127'd0, out_valid_s[1]}, 128'd0);
        chk("idle_out_hold", out_data_s[1], exp);

        // Reset two cycles into RUN.
        accept(1, 2'b00, D1, cin);
        ov_seen = out_valid_s[1];
        @(posedge clk);
        #1 ov_seen |= out_valid_s[1];
        @(negedge clk);
        rst_s[1] = 1'b1;
        @(posedge clk);
        #1 rst_s[1] = 1'b0;
        chk("mrst_busy", {127'd0, busy_s[1]}, 128'd0);
        chk("mrst_chain", chain_s[1], 128'd0);
        chk("mrst_in_ready", {127'd0, in_ready_s[1]}, 128'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 ov_seen |= out_valid_s[1];
        end
        chk("mrst_no_output", {127'd0, ov_seen}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
